// File: rtl/alu_rr_sequencer_if.sv
// Request/response handshake bundle between two clients and the ALU sequencer.
// ALU_RR_SEQUENCER_FLAGS_EN adds the registered zero/negative response flags.
interface alu_rr_sequencer_if #(parameter int WIDTH = 32);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [3:0]         req_op;
  logic [1:0]         req_sub;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_data;
`ifdef ALU_RR_SEQUENCER_FLAGS_EN
  logic               rsp_zero;
  logic               rsp_neg;

  modport master (
    output req_valid, req_op, req_sub, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_neg
  );
  modport slave (
    input  req_valid, req_op, req_sub, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_neg
  );
`else
  modport master (
    output req_valid, req_op, req_sub, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input  req_valid, req_op, req_sub, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
`endif
endinterface

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Optional ALU_RR_SEQUENCER_FLAGS_EN adds registered rsp_zero/rsp_neg flags.
module alu_rr_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_rr_sequencer_if.slave bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_op,
  output logic              alu_sub,
  input  logic [WIDTH-1:0]  alu_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             rr_ptr;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic             any_req;
  logic             grant;
  logic [1:0]       g_op;
  logic             g_sub;
  logic [WIDTH-1:0] g_a;
  logic [WIDTH-1:0] g_b;

  // The rr_ptr requester wins when valid; otherwise a lone requester is served.
  always_comb begin
    any_req = |bus.req_valid;
    grant   = bus.req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    g_op    = grant ? bus.req_op[3:2]            : bus.req_op[1:0];
    g_sub   = grant ? bus.req_sub[1]             : bus.req_sub[0];
    g_a     = grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    g_b     = grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
  end

  // rst_n gates the accept so nothing is offered while reset is held.
  assign bus.req_ready = (rst_n && state == IDLE && any_req) ?
                         (grant ? 2'b10 : 2'b01) : 2'b00;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef ALU_RR_SEQUENCER_FLAGS_EN
  logic rsp_zero_q;
  logic rsp_neg_q;

  assign bus.rsp_zero = rsp_zero_q;
  assign bus.rsp_neg  = rsp_neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero_q <= 1'b0;
      rsp_neg_q  <= 1'b0;
    end else if (state == EXEC) begin
      rsp_zero_q <= (alu_out == '0);
      rsp_neg_q  <= alu_out[WIDTH-1];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 2'b00;
      alu_sub     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            alu_a    <= g_a;
            alu_b    <= g_b;
            alu_op   <= g_op;
            alu_sub  <= g_sub;
            rsp_id_q <= grant;
            rr_ptr   <= ~grant;
            state    <= EXEC;
          end
        end
        // ALU inputs have been stable for a full cycle; capture its result.
        EXEC: begin
          rsp_data_q  <= alu_out;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboard bench for alu_rr_sequencer with a behavioural ALU on its alu_* port.
module tb_alu_rr_sequencer;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_rr_sequencer_if #(.WIDTH(WIDTH)) bus ();
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [1:0]       alu_op;
  logic             alu_sub;

  alu_rr_sequencer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_sub (alu_sub),
    .alu_out (alu_out)
  );

  function automatic logic [31:0] alu_f(input logic [1:0] op, input logic s,
                                        input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return s ? (a - b) : (a + b);
      default: return {31'b0, (a < b)};
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_sub, alu_a, alu_b);

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got id=%0d data=%h exp=none", bus.rsp_id, bus.rsp_data);
      end else begin
        mon_e = sb.pop_front();
        if ({bus.rsp_id, bus.rsp_data} !== {mon_e.id, mon_e.data}) begin
          failures++;
          $display("FAIL rsp_data got id=%0d data=%h exp id=%0d data=%h",
                   bus.rsp_id, bus.rsp_data, mon_e.id, mon_e.data);
        end
`ifdef ALU_RR_SEQUENCER_FLAGS_EN
        checks++;
        if ({bus.rsp_zero, bus.rsp_neg} !== {(mon_e.data == 32'h0), mon_e.data[31]}) begin
          failures++;
          $display("FAIL rsp_flags got zero=%0d neg=%0d exp zero=%0d neg=%0d",
                   bus.rsp_zero, bus.rsp_neg, (mon_e.data == 32'h0), mon_e.data[31]);
        end
`endif
      end
    end
  end

  task automatic set_req(input int r, input logic [1:0] op, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      bus.req_op[1:0] = op; bus.req_sub[0] = s; bus.req_a[31:0] = a; bus.req_b[31:0] = b;
    end else begin
      bus.req_op[3:2] = op; bus.req_sub[1] = s; bus.req_a[63:32] = a; bus.req_b[63:32] = b;
    end
  endtask

  // Returns just before the accepting edge; g is 00 if no grant came in time.
  task automatic wait_grant(output logic [1:0] g);
    int n = 0;
    #1;
    while (bus.req_ready == 2'b00 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    g = bus.req_ready;
  endtask

  task automatic reset_dut();
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, alu_a, alu_b, alu_op, alu_sub} !== '0) begin
      failures++;
      $display("FAIL reset_state got valid=%0d id=%0d data=%h a=%h b=%h op=%0d sub=%0d exp all zero",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data, alu_a, alu_b, alu_op, alu_sub);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready);
    end
    reset_dut();
  endtask

  task automatic test_single();
    logic [1:0] g;
    @(negedge clk); #1;
    set_req(0, 2'b10, 1'b0, 32'h0, 32'h1);
    bus.req_valid = 2'b01;
    wait_grant(g);
    checks++;
    if (g !== 2'b01) begin
      failures++;
      $display("FAIL single_grant got=%b exp=01", g);
    end
    sb.push_back('{id: 1'b0, data: 32'h1});
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_exec_valid got=%0d exp=0", bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=1", bus.rsp_valid);
    end
    drain();
  endtask

  task automatic test_contention();
    logic [1:0] g;
    logic [1:0] exp_g;
    reset_dut();
    set_req(0, 2'b00, 1'b0, 32'h341B928C, 32'h12340149);
    set_req(1, 2'b10, 1'b1, 32'h5, 32'h3);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(g);
      checks++;
      if (g !== exp_g) begin
        failures++;
        $display("FAIL contention_grant%0d got=%b exp=%b", k, g, exp_g);
      end
      if (g == 2'b01) sb.push_back('{id: 1'b0, data: 32'h10100008});
      if (g == 2'b10) sb.push_back('{id: 1'b1, data: 32'h00000002});
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    drain();
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    @(negedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_req(1, 2'b01, 1'b0, 32'h0, 32'h1);
    bus.req_valid = 2'b10;
    wait_grant(g);
    checks++;
    if (g !== 2'b10) begin
      failures++;
      $display("FAIL bp_grant got=%b exp=10", g);
    end
    sb.push_back('{id: 1'b1, data: 32'h1});
    @(posedge clk); #1;
    set_req(0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready} !== {1'b1, 1'b1, 32'h1, 2'b00}) begin
        failures++;
        $display("FAIL bp_hold%0d got valid=%0d id=%0d data=%h ready=%b exp 1 1 00000001 00",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_complete got=%0d exp=0", bus.rsp_valid);
    end
    drain();
  endtask

  task automatic test_lone();
    logic [1:0] g;
    logic [1:0] exp_g;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      set_req(0, 2'b01, 1'b0, 32'h0000_F000, 32'h0000_000F);
      set_req(1, 2'b10, 1'b1, 32'h0000_0010, 32'h0000_0001);
      bus.req_valid = (k < 2) ? 2'b10 : 2'b11;
      exp_g = (k < 2) ? 2'b10 : 2'b01;
      wait_grant(g);
      checks++;
      if (g !== exp_g) begin
        failures++;
        $display("FAIL lone_grant%0d got=%b exp=%b", k, g, exp_g);
      end
      if (g == 2'b01) sb.push_back('{id: 1'b0, data: 32'h0000_F00F});
      if (g == 2'b10) sb.push_back('{id: 1'b1, data: 32'h0000_000F});
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      drain();
    end
  endtask

  task automatic test_wrap_slt();
    logic [1:0] g;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      if (k == 0) set_req(0, 2'b10, 1'b0, 32'h8000_0000, 32'h8000_0000);
      else        set_req(0, 2'b11, 1'b0, 32'h1, 32'h11);
      bus.req_valid = 2'b01;
      wait_grant(g);
      checks++;
      if (g !== 2'b01) begin
        failures++;
        $display("FAIL wrap_slt_grant%0d got=%b exp=01", k, g);
      end
      sb.push_back('{id: 1'b0, data: (k == 0) ? 32'h0 : 32'h1});
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      drain();
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] g;
    @(negedge clk); #1;
    set_req(0, 2'b11, 1'b1, 32'h0000_1234, 32'h0000_5678);
    bus.req_valid = 2'b01;
    wait_grant(g);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rsp_valid, alu_a, alu_b, alu_op, alu_sub} !== '0) begin
      failures++;
      $display("FAIL rst_mid_immediate got valid=%0d a=%h b=%h op=%0d sub=%0d exp all zero",
               bus.rsp_valid, alu_a, alu_b, alu_op, alu_sub);
    end
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_no_rsp%0d got=%0d exp=0", i, bus.rsp_valid);
      end
    end
    #1;
    set_req(0, 2'b00, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    set_req(1, 2'b01, 1'b0, 32'h1, 32'h2);
    bus.req_valid = 2'b11;
    wait_grant(g);
    checks++;
    if (g !== 2'b01) begin
      failures++;
      $display("FAIL rst_mid_regrant got=%b exp=01", g);
    end
    if (g == 2'b01) sb.push_back('{id: 1'b0, data: 32'hF000_F000});
    if (g == 2'b10) sb.push_back('{id: 1'b1, data: 32'h3});
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    drain();
  endtask

  task automatic test_random();
    logic [1:0]  g;
    logic [1:0]  mask;
    logic [1:0]  exp_g;
    logic        tb_ptr;
    logic        gi;
    logic [1:0]  op_r [2];
    logic        sub_r [2];
    logic [31:0] a_r [2];
    logic [31:0] b_r [2];
    reset_dut();
    tb_ptr = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        op_r[r]  = 2'($urandom_range(0, 3));
        sub_r[r] = 1'($urandom_range(0, 1));
        a_r[r]   = $urandom;
        b_r[r]   = (k % 3 == 0) ? a_r[r] : $urandom;
        set_req(r, op_r[r], sub_r[r], a_r[r], b_r[r]);
      end
      mask = 2'($urandom_range(1, 3));
      gi = mask[tb_ptr] ? tb_ptr : ~tb_ptr;
      exp_g = gi ? 2'b10 : 2'b01;
      tb_ptr = ~gi;
      bus.req_valid = mask;
      wait_grant(g);
      checks++;
      if (g !== exp_g) begin
        failures++;
        $display("FAIL random_grant%0d got=%b exp=%b mask=%b", k, g, exp_g, mask);
      end
      sb.push_back('{id: gi, data: alu_f(op_r[gi], sub_r[gi], a_r[gi], b_r[gi])});
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      drain();
    end
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_op    = 4'h0;
    bus.req_sub   = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_lone();
    test_wrap_slt();
    test_reset_mid();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
